// File: rtl/fma_pkg.sv
// Shared encodings, flag layout and beat-plan helper for the FMA result serializer.
package fma_pkg;

    // Format encodings used for both source mode and result precision.
    localparam logic [1:0] FMT_DP = 2'b11;
    localparam logic [1:0] FMT_SP = 2'b10;
    localparam logic [1:0] FMT_HP = 2'b01;

    // Bit positions inside the 5-bit beat flag vector {nan, inf, of, uf, z}.
    localparam int unsigned FLAG_Z   = 0;
    localparam int unsigned FLAG_UF  = 1;
    localparam int unsigned FLAG_OF  = 2;
    localparam int unsigned FLAG_INF = 3;
    localparam int unsigned FLAG_NAN = 4;

    // Bit positions inside the sticky accrued vector {NV, OF, UF}.
    localparam int unsigned ACC_UF = 0;
    localparam int unsigned ACC_OF = 1;
    localparam int unsigned ACC_NV = 2;

    typedef enum logic {StIdle, StSend} state_e;

    // Per-lane flags of one captured result set, one bit per lane.
    typedef struct packed {
        logic [3:0] nan;
        logic [3:0] inf;
        logic [3:0] of;
        logic [3:0] uf;
        logic [3:0] z;
    } lane_flags_t;

    // Number of output beats for a {mode, precision} pair; unknown codes act as DP->DP.
    function automatic logic [2:0] beat_count(input logic [1:0] mode, input logic [1:0] precision);
        case ({mode, precision})
            {FMT_SP, FMT_DP}: return 3'd2;
            {FMT_HP, FMT_DP}: return 3'd4;
            {FMT_HP, FMT_SP}: return 3'd2;
            default:          return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/fma_beat_pack.sv
// Combinational beat packer: selects and packs the lanes carried by one output beat.
module fma_beat_pack
    import fma_pkg::*;
(
    input  logic [3:0][63:0] res_i,
    input  lane_flags_t      flags_i,
    input  logic [1:0]       mode_i,
    input  logic [1:0]       precision_i,
    input  logic [1:0]       beat_i,
    output logic [63:0]      data_o,
    output logic [4:0]       flags_o,
    output logic             last_o
);

    logic [3:0] lane_sel;
    logic [2:0] n_beats;

    assign n_beats = beat_count(mode_i, precision_i);
    assign last_o  = ({1'b0, beat_i} == (n_beats - 3'd1));

    // Pick the beat payload and remember which lanes it carries.
    always_comb begin
        data_o   = res_i[0];
        lane_sel = 4'b0001;
        case ({mode_i, precision_i})
            {FMT_SP, FMT_DP}, {FMT_HP, FMT_DP}: begin
                data_o   = res_i[beat_i];
                lane_sel = 4'b0001 << beat_i;
            end
            {FMT_SP, FMT_SP}: begin
                data_o   = {res_i[1][31:0], res_i[0][31:0]};
                lane_sel = 4'b0011;
            end
            {FMT_HP, FMT_SP}: begin
                if (beat_i[0]) begin
                    data_o   = {res_i[3][31:0], res_i[2][31:0]};
                    lane_sel = 4'b1100;
                end else begin
                    data_o   = {res_i[1][31:0], res_i[0][31:0]};
                    lane_sel = 4'b0011;
                end
            end
            {FMT_HP, FMT_HP}: begin
                data_o   = {res_i[3][15:0], res_i[2][15:0], res_i[1][15:0], res_i[0][15:0]};
                lane_sel = 4'b1111;
            end
            default: ;
        endcase
    end

    // Flags cover only the lanes present in this beat.
    always_comb begin
        flags_o           = '0;
        flags_o[FLAG_NAN] = |(flags_i.nan & lane_sel);
        flags_o[FLAG_INF] = |(flags_i.inf & lane_sel);
        flags_o[FLAG_OF]  = |(flags_i.of & lane_sel);
        flags_o[FLAG_UF]  = |(flags_i.uf & lane_sel);
        flags_o[FLAG_Z]   = |(flags_i.z & lane_sel);
    end

endmodule

// File: rtl/fma_result_serializer.sv
// Captures a four-lane FMA result set and streams it as 64-bit beats with sticky flags.
module fma_result_serializer
    import fma_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [1:0]       in_precision,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [63:0]      in_res0,
    input  logic [63:0]      in_res1,
    input  logic [63:0]      in_res2,
    input  logic [63:0]      in_res3,
    input  logic [3:0]       in_uf,
    input  logic [3:0]       in_of,
    input  logic [3:0]       in_inf,
    input  logic [3:0]       in_z,
    input  logic [3:0]       in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [4:0]       out_flags,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       acc_flags,
    input  logic             acc_clr
);

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0][63:0]  res_q, res_d;
    lane_flags_t       flags_q, flags_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        prec_q, prec_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [63:0]       data_q, data_d;
    logic [4:0]        oflags_q, oflags_d;
    logic              last_q, last_d;
    logic [2:0]        acc_q, acc_d;

    logic              out_hs;
    logic              accept;
    logic [63:0]       pack_data;
    logic [4:0]        pack_flags;
    logic              pack_last;

    assign out_valid = (state_q == StSend);
    assign out_hs    = out_valid & out_ready;
    // Last-beat handshake frees the capture registers in the same cycle, so sets stream gap-free.
    assign in_ready  = (state_q == StIdle) | (out_hs & last_q);
    assign accept    = in_valid & in_ready;

    assign out_data  = data_q;
    assign out_flags = oflags_q;
    assign out_last  = last_q;
    assign out_tag   = tag_q;
    assign acc_flags = acc_q;

    // Packer looks at next-state values so beat outputs can be registered.
    fma_beat_pack u_pack (
        .res_i       (res_d),
        .flags_i     (flags_d),
        .mode_i      (mode_d),
        .precision_i (prec_d),
        .beat_i      (beat_d),
        .data_o      (pack_data),
        .flags_o     (pack_flags),
        .last_o      (pack_last)
    );

    // Capture, beat sequencing, registered beat outputs and sticky flag update.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        res_d   = res_q;
        flags_d = flags_q;
        mode_d  = mode_q;
        prec_d  = prec_q;
        tag_d   = tag_q;

        if (accept) begin
            res_d       = {in_res3, in_res2, in_res1, in_res0};
            flags_d.nan = in_nan;
            flags_d.inf = in_inf;
            flags_d.of  = in_of;
            flags_d.uf  = in_uf;
            flags_d.z   = in_z;
            mode_d      = in_mode;
            prec_d      = in_precision;
            tag_d       = in_tag;
            state_d     = StSend;
            beat_d      = 2'd0;
        end else if (out_hs) begin
            if (last_q) begin
                state_d = StIdle;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end

        data_d   = (state_d == StSend) ? pack_data : '0;
        oflags_d = (state_d == StSend) ? pack_flags : '0;
        last_d   = (state_d == StSend) & pack_last;

        // Clear first, then accrue, so a handshake in a clear cycle is not lost.
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end
        if (out_hs) begin
            acc_d[ACC_NV] = acc_d[ACC_NV] | oflags_q[FLAG_NAN];
            acc_d[ACC_OF] = acc_d[ACC_OF] | oflags_q[FLAG_OF];
            acc_d[ACC_UF] = acc_d[ACC_UF] | oflags_q[FLAG_UF];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            mode_q   <= '0;
            prec_q   <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            oflags_q <= '0;
            last_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            mode_q   <= mode_d;
            prec_q   <= prec_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            oflags_q <= oflags_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_fma_result_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a beat-list model.
module tb_fma_result_serializer;

    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [63:0]      d;
        logic [4:0]       f;
        logic             l;
        logic [TAG_W-1:0] t;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [1:0]       in_precision;
    logic [TAG_W-1:0] in_tag;
    logic [63:0]      in_res0, in_res1, in_res2, in_res3;
    logic [3:0]       in_uf, in_of, in_inf, in_z, in_nan;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [4:0]       out_flags;
    logic             out_last;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       acc_flags;
    logic             acc_clr;

    int    tests  = 0;
    int    failed = 0;
    bit    armed  = 0;
    beat_t exp_q[$];
    logic [2:0] acc_model = '0;

    fma_result_serializer #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_precision (in_precision),
        .in_tag       (in_tag),
        .in_res0      (in_res0),
        .in_res1      (in_res1),
        .in_res2      (in_res2),
        .in_res3      (in_res3),
        .in_uf        (in_uf),
        .in_of        (in_of),
        .in_inf       (in_inf),
        .in_z         (in_z),
        .in_nan       (in_nan),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_last     (out_last),
        .out_tag      (out_tag),
        .acc_flags    (acc_flags),
        .acc_clr      (acc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Element width in bits of a format code; 0 for an unknown code.
    function automatic int fmt_w(input logic [1:0] f);
        case (f)
            2'b11:   return 64;
            2'b10:   return 32;
            2'b01:   return 16;
            default: return 0;
        endcase
    endfunction

    // Expand the set on the input pins into its list of expected beats.
    task automatic push_set();
        logic [63:0] res [4];
        logic [63:0] v;
        logic [1:0]  m, p;
        int          w, lanes, lpb, nb, ln;
        beat_t       bt;
        res = '{in_res0, in_res1, in_res2, in_res3};
        m = in_mode;
        p = in_precision;
        if (fmt_w(m) == 0 || fmt_w(p) == 0 || fmt_w(p) < fmt_w(m)) begin
            m = 2'b11;
            p = 2'b11;
        end
        w     = fmt_w(p);
        lanes = 64 / fmt_w(m);
        lpb   = 64 / w;
        nb    = lanes / lpb;
        for (int b = 0; b < nb; b++) begin
            bt.d = '0;
            bt.f = '0;
            bt.t = in_tag;
            bt.l = (b == nb - 1);
            for (int k = 0; k < lpb; k++) begin
                ln = b * lpb + k;
                v  = res[ln];
                if (w < 64) v = v & ((64'd1 << w) - 64'd1);
                bt.d = bt.d | (v << (k * w));
                bt.f = bt.f | {in_nan[ln], in_inf[ln], in_of[ln], in_uf[ln], in_z[ln]};
            end
            exp_q.push_back(bt);
        end
    endtask

    // Monitor: compare every cycle against the model, then advance the model past the next edge.
    always @(negedge clk) begin
        logic exp_rdy;
        if (armed) begin
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("mon.in_ready", 64'(in_ready), 64'(exp_rdy));
            check("mon.out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("mon.data", out_data, exp_q[0].d);
                check("mon.flags", 64'(out_flags), 64'(exp_q[0].f));
                check("mon.last", 64'(out_last), 64'(exp_q[0].l));
                check("mon.tag", 64'(out_tag), 64'(exp_q[0].t));
            end
            check("mon.acc", 64'(acc_flags), 64'(acc_model));
            if (!rst_n) begin
                exp_q.delete();
                acc_model = '0;
            end else begin
                if (acc_clr) acc_model = '0;
                if (exp_q.size() != 0 && out_ready) begin
                    acc_model = acc_model | {exp_q[0].f[4], exp_q[0].f[2], exp_q[0].f[1]};
                    void'(exp_q.pop_front());
                end
                if (in_valid && exp_rdy) push_set();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input logic [1:0] m, input logic [1:0] p, input logic [3:0] tag,
                             input logic [63:0] r0, input logic [63:0] r1,
                             input logic [63:0] r2, input logic [63:0] r3,
                             input logic [3:0] of, input logic [3:0] nan);
        in_valid     = 1'b1;
        in_mode      = m;
        in_precision = p;
        in_tag       = tag;
        in_res0      = r0;
        in_res1      = r1;
        in_res2      = r2;
        in_res3      = r3;
        in_of        = of;
        in_nan       = nan;
        in_uf        = 4'h0;
        in_inf       = 4'h0;
        in_z         = 4'h0;
    endtask

    // Wait (bounded) for a handshaking beat and check its payload.
    task automatic expect_beat(input string tag, input logic [63:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".hs"}, 64'(out_valid && out_ready), 64'd1);
        check({tag, ".data"}, out_data, d);
        check({tag, ".last"}, 64'(out_last), 64'(l));
    endtask

    logic [3:0] codes [6];

    initial begin
        int n;
        codes = '{4'hF, 4'hB, 4'h7, 4'hA, 4'h6, 4'h5};
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        acc_clr = 1'b0;
        drive_set(2'b00, 2'b00, 4'h0, '0, '0, '0, '0, 4'h0, 4'h0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.out_data", out_data, 64'd0);
        check("rst.out_flags", 64'(out_flags), 64'd0);
        check("rst.out_last", 64'(out_last), 64'd0);
        check("rst.out_tag", 64'(out_tag), 64'd0);
        check("rst.acc", 64'(acc_flags), 64'd0);
        rst_n = 1'b1;
        armed = 1'b1;
        tick();
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // DP->DP single beat; in_ready high in the same cycle as the last beat.
        out_ready = 1'b1;
        drive_set(2'b11, 2'b11, 4'h1, 64'h3FF0000000000000, 64'h1, 64'h2, 64'h3, 4'h0, 4'h0);
        tick();
        in_valid = 1'b0;
        expect_beat("t1", 64'h3FF0000000000000, 1'b1);
        check("t1.in_ready", 64'(in_ready), 64'd1);

        // HP->SP two beats.
        tick();
        drive_set(2'b01, 2'b10, 4'h2, 64'h3F800000, 64'h40000000, 64'h40400000, 64'h40800000,
                  4'h0, 4'h0);
        tick();
        in_valid = 1'b0;
        expect_beat("t2.b0", 64'h40000000_3F800000, 1'b0);
        expect_beat("t2.b1", 64'h40800000_40400000, 1'b1);

        // HP->DP four beats with a stall on beat 2.
        tick();
        drive_set(2'b01, 2'b11, 4'hA, 64'h1111111111111111, 64'h2222222222222222,
                  64'h3333333333333333, 64'h4444444444444444, 4'h0, 4'h0);
        tick();
        in_valid = 1'b0;
        expect_beat("t3.b0", 64'h1111111111111111, 1'b0);
        expect_beat("t3.b1", 64'h2222222222222222, 1'b0);
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t3.hold.data", out_data, 64'h3333333333333333);
            check("t3.hold.tag", 64'(out_tag), 64'hA);
        end
        tick();
        out_ready = 1'b1;
        expect_beat("t3.b2", 64'h3333333333333333, 1'b0);
        expect_beat("t3.b3", 64'h4444444444444444, 1'b1);

        // HP->HP one beat with overflow on lane 2.
        tick();
        drive_set(2'b01, 2'b01, 4'h4, 64'h3C00, 64'h4000, 64'h4200, 64'h4400, 4'b0100, 4'h0);
        tick();
        in_valid = 1'b0;
        expect_beat("t4", 64'h4400420040003C00, 1'b1);
        check("t4.flags", 64'(out_flags), 64'b00100);
        tick();
        check("t4.acc", 64'(acc_flags), 64'b010);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("t4.acc_clr", 64'(acc_flags), 64'd0);

        // Back-to-back: SP->DP set then a DP set with NaN, streamed with no bubble.
        drive_set(2'b10, 2'b11, 4'h2, 64'hAAAA0000AAAA0000, 64'hBBBB0000BBBB0000, '0, '0,
                  4'h0, 4'h0);
        tick();
        drive_set(2'b11, 2'b11, 4'h3, 64'hDEADBEEFCAFEF00D, '0, '0, '0, 4'h0, 4'b0001);
        n = 0;
        do begin
            @(negedge clk);
            check("t5.no_bubble", 64'(out_valid), 64'd1);
            n++;
        end while (!in_ready && n < 10);
        check("t5.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        acc_clr = 1'b1;
        @(negedge clk);
        check("t5.b.valid", 64'(out_valid), 64'd1);
        check("t5.b.data", out_data, 64'hDEADBEEFCAFEF00D);
        check("t5.b.tag", 64'(out_tag), 64'h3);
        tick();
        acc_clr = 1'b0;
        check("t5.acc_nv", 64'(acc_flags), 64'b100);

        // Reset during beat 1 of an SP->DP set.
        drive_set(2'b10, 2'b11, 4'h5, 64'h5555, 64'h6666, '0, '0, 4'h0, 4'h0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t6.beat1", out_data, 64'h6666);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6.out_valid", 64'(out_valid), 64'd0);
        check("t6.in_ready", 64'(in_ready), 64'd1);
        repeat (5) begin
            tick();
            check("t6.no_beat", 64'(out_valid), 64'd0);
        end

        // Randomized traffic, including unknown codes, stalls, clears and resets.
        for (int c = 0; c < 1500; c++) begin
            tick();
            rst_n     = ($urandom_range(0, 249) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0) begin
                {in_mode, in_precision} = codes[$urandom_range(0, 5)];
            end else begin
                {in_mode, in_precision} = 4'($urandom);
            end
            in_tag  = 4'($urandom);
            in_res0 = {$urandom, $urandom};
            in_res1 = {$urandom, $urandom};
            in_res2 = {$urandom, $urandom};
            in_res3 = {$urandom, $urandom};
            in_nan  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            in_inf  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            in_of   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            in_uf   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            in_z    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
        end

        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        acc_clr = 1'b0;
        repeat (12) tick();
        check("drain.pending", 64'(exp_q.size()), 64'd0);
        check("drain.out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
